// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: round-robin arbiter sharing one binary->BCD converter
// among N_REQ sources, with saturation at MAX_VAL and a done pulse per result.
module bcd_conv_sched #(
    parameter int N_REQ    = 3,
    parameter int BIN_W    = 24,
    parameter int CONV_LAT = 1,
    parameter int MAX_VAL  = 9999999
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*BIN_W-1:0] bin_in,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       done,
    output logic [27:0]            bcd_out,
    output logic                   ovf,
    output logic                   busy,
    output logic [BIN_W-1:0]       conv_bin,
    input  logic [27:0]            conv_bcd
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [BIN_W-1:0] MAX_V    = BIN_W'(MAX_VAL);
    localparam logic [3:0]       CNT_LAST = 4'(CONV_LAT);
    localparam logic [PW-1:0]    LAST_IDX = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t           state, state_d;
    logic [PW-1:0]    ptr, ptr_d;
    logic [PW-1:0]    gidx, gidx_d;
    logic [3:0]       cnt, cnt_d;
    logic             ovf_pend, ovf_pend_d;
    logic [BIN_W-1:0] conv_bin_d;
    logic [27:0]      bcd_d;
    logic             ovf_d;
    logic [N_REQ-1:0] ack_d, done_d;

    logic             hit;
    logic [PW-1:0]    pick;
    logic [PW-1:0]    pick_nxt;
    logic [BIN_W-1:0] bin_sel;
    logic             sat;
    int               j;

    // First requesting source at or above ptr, wrapping around.
    always_comb begin
        hit  = 1'b0;
        pick = '0;
        j    = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!hit && req[j]) begin
                hit  = 1'b1;
                pick = PW'(j);
            end
        end
    end

    assign bin_sel  = bin_in[int'(pick)*BIN_W +: BIN_W];
    assign sat      = (bin_sel > MAX_V);
    assign pick_nxt = (pick == LAST_IDX) ? '0 : pick + 1'b1;

    // Next-state and next registered-output values.
    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        gidx_d     = gidx;
        cnt_d      = cnt;
        ovf_pend_d = ovf_pend;
        conv_bin_d = conv_bin;
        bcd_d      = bcd_out;
        ovf_d      = ovf;
        ack_d      = '0;
        done_d     = '0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    state_d    = WAIT;
                    gidx_d     = pick;
                    ptr_d      = pick_nxt;
                    cnt_d      = '0;
                    conv_bin_d = sat ? MAX_V : bin_sel;
                    ovf_pend_d = sat;
                    ack_d      = N_REQ'(1) << pick;
                end
            end
            WAIT: begin
                if (cnt == CNT_LAST) begin
                    state_d = DONE;
                    bcd_d   = conv_bcd;
                    ovf_d   = ovf_pend;
                    done_d  = N_REQ'(1) << gidx;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight conversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gidx     <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            conv_bin <= '0;
            bcd_out  <= '0;
            ovf      <= 1'b0;
            ack      <= '0;
            done     <= '0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            gidx     <= gidx_d;
            cnt      <= cnt_d;
            ovf_pend <= ovf_pend_d;
            conv_bin <= conv_bin_d;
            bcd_out  <= bcd_d;
            ovf      <= ovf_d;
            ack      <= ack_d;
            done     <= done_d;
            busy     <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched: scoreboard bench with a converter model, directed
// corner cases and randomized per-source request traffic.
module tb_bcd_conv_sched;

    localparam int N    = 3;
    localparam int W    = 24;
    localparam int LAT  = 1;
    localparam int MAXV = 9999999;

    typedef struct {
        logic [27:0] bcd;
        logic        ovf;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req;
    logic [N*W-1:0] bin_in;
    logic [N-1:0]   ack;
    logic [N-1:0]   done;
    logic [27:0]    bcd_out;
    logic           ovf;
    logic           busy;
    logic [W-1:0]   conv_bin;
    logic [27:0]    conv_bcd = '0;

    logic           req_a [N];
    logic [W-1:0]   bin_a [N];
    exp_t           exp_q [N][$];

    int n_cmp = 0;
    int n_err = 0;

    bcd_conv_sched #(
        .N_REQ(N), .BIN_W(W), .CONV_LAT(LAT), .MAX_VAL(MAXV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .bin_in(bin_in),
        .ack(ack), .done(done), .bcd_out(bcd_out), .ovf(ovf),
        .busy(busy), .conv_bin(conv_bin), .conv_bcd(conv_bcd)
    );

    always #5 clk = ~clk;

    always_comb begin
        req    = '0;
        bin_in = '0;
        for (int k = 0; k < N; k++) begin
            req[k]          = req_a[k];
            bin_in[k*W +: W] = bin_a[k];
        end
    end

    function automatic logic [27:0] to_bcd(logic [W-1:0] v);
        logic [27:0] r;
        int unsigned x;
        x = v;
        r = '0;
        for (int i = 0; i < 7; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Shared converter: one-clock registered binary -> BCD.
    always @(posedge clk) conv_bcd <= to_bcd(conv_bin);

    function automatic logic [27:0] ref_bcd(int unsigned v);
        logic [27:0] r;
        string s;
        int unsigned c;
        c = (v > MAXV) ? MAXV : v;
        s = $sformatf("%07d", c);
        r = '0;
        for (int i = 0; i < 7; i++)
            r[4*(6-i) +: 4] = 4'(s[i] - 8'd48);
        return r;
    endfunction

    function automatic int rr_pick(int p, logic [N-1:0] r);
        for (int i = 0; i < N; i++)
            if (r[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    task automatic check(string name, longint act, longint want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    task automatic raise(int k, int unsigned v);
        exp_t e;
        e.bcd = ref_bcd(v);
        e.ovf = (v > MAXV);
        exp_q[k].push_back(e);
        bin_a[k] = W'(v);
        req_a[k] = 1'b1;
    endtask

    task automatic wait_ack(int k);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (ack[k]) begin
                req_a[k] = 1'b0;
                return;
            end
        end
        n_cmp++;
        n_err++;
        $display("FAIL ack_timeout: source %0d got no ack, want ack", k);
        req_a[k] = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = !busy;
            for (int k = 0; k < N; k++)
                if (exp_q[k].size() != 0) ok = 0;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: results outstanding, want none");
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: round-robin order, timing and result scoreboard.
    int           cyc = 0;
    int           mptr = 0;
    int           last_ack = -100;
    int           exp_grant = -1;
    int           ack_cyc [N];
    int           wait_cnt [N];
    logic [N-1:0] req_last = '0;

    always @(negedge clk) begin : mon
        int   k;
        int   w;
        exp_t e;
        cyc++;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                exp_q[i].delete();
                wait_cnt[i] = 0;
                ack_cyc[i]  = 0;
            end
            mptr      = 0;
            last_ack  = -100;
            exp_grant = -1;
            req_last  = '0;
        end else begin
            if (exp_grant == cyc) check("b2b_grant", longint'(ack != 0), 1);
            if (ack != 0) begin
                check("ack_onehot", longint'($onehot(ack)), 1);
                k = 0;
                for (int i = N - 1; i >= 0; i--) if (ack[i]) k = i;
                w = rr_pick(mptr, req_last);
                check("rr_winner", k, w);
                check("ack_spacing", longint'(cyc - last_ack >= LAT + 3), 1);
                check("no_skip_twice", longint'(wait_cnt[k] <= N - 1), 1);
                wait_cnt[k] = 0;
                for (int i = 0; i < N; i++)
                    if (i != k && req_last[i]) wait_cnt[i]++;
                mptr       = (k + 1) % N;
                last_ack   = cyc;
                ack_cyc[k] = cyc;
            end
            if (cyc == last_ack + LAT + 2 && req != 0) exp_grant = cyc + 1;
            if (done != 0) begin
                check("done_onehot", longint'($onehot(done)), 1);
                k = 0;
                for (int i = N - 1; i >= 0; i--) if (done[i]) k = i;
                check("done_latency", cyc - ack_cyc[k], LAT + 1);
                if (exp_q[k].size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_done: source %0d, want no done", k);
                end else begin
                    e = exp_q[k].pop_front();
                    check("bcd_out", bcd_out, e.bcd);
                    check("ovf", ovf, e.ovf);
                end
            end
            req_last = req;
        end
    end

    task automatic src_run(int k);
        int          gap;
        int unsigned v;
        for (int n = 0; n < 12; n++) begin
            gap = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            case ($urandom_range(0, 5))
                0: v = $urandom & 32'hFFFFFF;
                1: v = MAXV;
                2: v = MAXV + 1;
                3: v = 0;
                default: v = $urandom_range(0, MAXV);
            endcase
            raise(k, v);
            wait_ack(k);
            if ($urandom_range(0, 1) == 1) bin_a[k] = W'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            req_a[k] = 1'b0;
            bin_a[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", ack, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_conv_bin", conv_bin, 0);
        check("rst_bcd", bcd_out, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        raise(0, 123456);
        wait_ack(0);
        check("conv_bin_123456", conv_bin, 123456);
        check("busy_wait", busy, 1);
        wait_idle();

        raise(0, 32'hFFFFFF);
        wait_ack(0);
        check("conv_bin_sat", conv_bin, 24'h98967F);
        wait_idle();
        check("ovf_held", ovf, 1);
        check("bcd_held", bcd_out, 28'h9999999);
        raise(1, MAXV);
        wait_ack(1);
        wait_idle();
        raise(2, 0);
        wait_ack(2);
        wait_idle();
        raise(0, MAXV + 1);
        wait_ack(0);
        wait_idle();

        raise(2, 555);
        wait_ack(2);
        bin_a[2] = 24'd777777;
        @(posedge clk);
        #1;
        check("conv_bin_stable", conv_bin, 555);
        wait_idle();

        raise(1, 4242);
        wait_ack(1);
        rst_n = 1'b0;
        #1;
        check("arst_ack", ack, 0);
        check("arst_busy", busy, 0);
        check("arst_conv_bin", conv_bin, 0);
        check("arst_bcd", bcd_out, 0);
        check("arst_ovf", ovf, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        raise(0, 1111);
        raise(1, 2222);
        for (int i = 0; i < 20 && ack == 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("post_rst_first", ack, 3'b001);
        req_a[0] = 1'b0;
        wait_ack(1);
        wait_idle();

        for (int k = 0; k < N; k++) begin
            fork
                automatic int kk = k;
                begin
                    src_run(kk);
                end
            join_none
        end
        wait fork;
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
